// File: rtl/func_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : func_sequencer
// Description : Instruction queue and issue sequencer that feeds `processor`.
//               A host pushes 24-bit instruction words into an internal FIFO.
//               The sequencer pops one word at a time and presents it on
//               `func` with a one-cycle `new_func` strobe. It then holds the
//               word until the processor reports completion on `proc_done`.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   When defined, a WAIT-cycle counter aborts an instruction after TIMEOUT
//   cycles without a qualifying `proc_done` and sets sticky `timeout_err`.
//   When undefined, WAIT lasts until `proc_done` and `timeout_err` is 0.
//
// Parameters  : DEPTH   - FIFO entries (power of two, >= 2)
//               TIMEOUT - maximum WAIT cycles before abort (>= 2)
//
// Ports       : clk         in   system clock, rising edge
//               reset       in   asynchronous active-low reset
//               run         in   issue enable (an active WAIT still completes)
//               wr_en       in   push wr_data into the FIFO
//               wr_data     in   [23:0] {opcode, rx, ry/imm}
//               proc_done   in   processor finished current instruction
//               err_clr     in   clears sticky overflow / timeout_err
//               func        out  [23:0] instruction to processor, registered
//               new_func    out  one-cycle issue strobe, registered
//               start       out  registered copy of run
//               busy        out  high while in WAIT
//               full        out  count == DEPTH
//               empty       out  count == 0
//               count       out  [log2(DEPTH):0] FIFO occupancy
//               overflow    out  sticky: write attempted while full
//               timeout_err out  sticky: WAIT exceeded TIMEOUT
//
// Revision    : 1.0 - initial release
// ============================================================================
module func_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     wr_en,
  input  logic [23:0]              wr_data,
  input  logic                     proc_done,
  input  logic                     err_clr,
  output logic [23:0]              func,
  output logic                     new_func,
  output logic                     start,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  localparam logic [0:0] c_S_IDLE = 1'b0;
  localparam logic [0:0] c_S_WAIT = 1'b1;

  // Elaboration-time guard on illegal parameter combinations.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_bad_params
      $error("func_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [23:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_nxt;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;

  logic [23:0]     r_func;
  logic            r_new_func;
  logic            r_start;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic            w_issue;
  logic            w_push;
  logic            w_done;
  logic            w_timeout;
  logic            w_busy;
  logic            w_new_func_nxt;

  assign w_full  = (r_count == c_CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // An issue is the only pop; it can never happen on an empty FIFO.
  assign w_issue = (r_state == c_S_IDLE) && run && !w_empty;

  // A write to a full FIFO is still accepted when the same edge pops,
  // because the pop frees the slot the write lands in.
  assign w_push  = wr_en && (!w_full || w_issue);

  // new_func is high exactly in the first WAIT cycle, so it doubles as the
  // "ignore proc_done this cycle" qualifier.
  assign w_done  = (r_state == c_S_WAIT) && !r_new_func && proc_done;

  // --------------------------------------------------------------------------
  // Optional WAIT timeout
  // --------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT + 1);

  logic [c_TW-1:0] r_tcnt;
  logic            r_timeout_err;

  // The counter holds the number of completed WAIT cycles; the edge that
  // closes the TIMEOUT-th WAIT cycle aborts unless proc_done qualifies on it.
  assign w_timeout = (r_state == c_S_WAIT) &&
                     (r_tcnt == c_TW'(TIMEOUT - 1)) && !w_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if (w_issue) begin
      r_tcnt <= '0;
    end else if (r_state == c_S_WAIT) begin
      r_tcnt <= r_tcnt + c_TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  // Memory contents need no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_issue})
      2'b10:   w_count_nxt = r_count + c_CW'(1);
      2'b01:   w_count_nxt = r_count - c_CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (err_clr) begin
      r_overflow <= 1'b0;
    end else if (wr_en && !w_push) begin
      r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = c_S_WAIT;
        end
      end
      c_S_WAIT: begin
        if (w_done || w_timeout) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // Sequencer FSM: output logic
  always_comb begin
    w_busy         = 1'b0;
    w_new_func_nxt = 1'b0;
    case (r_state)
      c_S_IDLE: w_new_func_nxt = w_issue;
      c_S_WAIT: w_busy         = 1'b1;
      default: begin
        w_busy         = 1'b0;
        w_new_func_nxt = 1'b0;
      end
    endcase
  end

  // Registered issue outputs; func only changes on an issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_func     <= 24'h000000;
      r_new_func <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_func <= r_mem[r_rd_ptr];
      end
      r_new_func <= w_new_func_nxt;
      r_start    <= run;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign func     = r_func;
  assign new_func = r_new_func;
  assign start    = r_start;
  assign busy     = w_busy;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_func_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_func_sequencer
// Description : Scoreboard bench for func_sequencer. Stimulus pushes the
//               expected issue words into a queue; a monitor pops and compares
//               whenever new_func is presented. A small processor model
//               answers proc_done after a programmed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_func_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b1;
  logic        wr_en = 1'b0;
  logic [23:0] wr_data = '0;
  logic        err_clr = 1'b0;
  logic        proc_done;
  logic        model_done = 1'b0;
  logic        man_done = 1'b0;
  logic        model_en = 1'b0;

  logic [23:0] func;
  logic        new_func;
  logic        start;
  logic        busy;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        timeout_err;

  assign proc_done = model_done | man_done;

  func_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .wr_en(wr_en), .wr_data(wr_data),
    .proc_done(proc_done), .err_clr(err_clr), .func(func),
    .new_func(new_func), .start(start), .busy(busy), .full(full),
    .empty(empty), .count(count), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [23:0] sb[$];
  int          lat_q[$];
  int          issue_cyc[$];
  int          n_issue = 0;
  int          cyc = 0;
  logic        rec_cyc = 1'b0;
  logic        prev_nf = 1'b0;
  int          last_cyc = -100;
  logic [23:0] last_func = '0;
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] w, input bit expect_issue);
    wr_en   = 1'b1;
    wr_data = w;
    if (expect_issue) sb.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < max) begin
      @(negedge clk);
      #1;
      n++;
      if (!busy && empty && !new_func && sb.size() == 0) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (new_func) begin
          n_issue++;
          if (rec_cyc) issue_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got func %0h with no word queued", func);
          end else begin
            chk("issue_func", {8'd0, func}, {8'd0, sb.pop_front()});
          end
          checks++;
          if (cyc - last_cyc < 3) begin
            errors++;
            $display("FAIL issue_spacing: got %0d cycles required >= 3", cyc - last_cyc);
          end
          chk("new_func_single_cycle", {31'd0, prev_nf}, 32'd0);
          last_cyc  = cyc;
          last_func = func;
        end else if (busy) begin
          chk("func_stable", {8'd0, func}, {8'd0, last_func});
        end
        prev_nf = new_func;
      end
    end
  end

  // Processor model: done pulse `lat` cycles after seeing new_func
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && new_func) begin
        lat = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
        repeat (lat) @(negedge clk);
        model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_func", {8'd0, func}, 32'h0);
    chk("rst_new_func", {31'd0, new_func}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("start_after_release", {31'd0, start}, 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_new_func", {31'd0, new_func}, 32'd0);
    chk("idle_func", {8'd0, func}, 32'h0);
    chk("idle_empty", {31'd0, empty}, 32'd1);

    // ---------------- single issue ----------------
    push(24'h000010, 1'b1);
    chk("lat_edge_n", {31'd0, new_func}, 32'd0);
    @(negedge clk);
    chk("lat_edge_n1", {31'd0, new_func}, 32'd1);
    chk("single_func", {8'd0, func}, 32'h000010);
    chk("single_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    chk("single_issue_count", n_issue, 1);

    // ---------------- back-to-back program ----------------
    model_en = 1'b1;
    lat_q = '{2, 2, 2, 4};
    push(24'h000010, 1'b1);
    push(24'h120000, 1'b1);
    push(24'h010004, 1'b1);
    push(24'h201000, 1'b1);
    wait_idle(200, "program_drain");
    chk("program_issue_count", n_issue, 5);

    // ---------------- full / overflow ----------------
    run = 1'b0;
    for (int i = 0; i < 9; i++) push(24'hA00000 + 24'(i), i < 8);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_count", {28'd0, count}, 32'd8);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("no_issue_run_low", n_issue, 5);
    err_clr = 1'b1;
    wr_en   = 1'b1;
    wr_data = 24'hBADBAD;
    @(negedge clk);
    err_clr = 1'b0;
    wr_en   = 1'b0;
    chk("err_clr_wins", {31'd0, overflow}, 32'd0);
    chk("full_count_hold", {28'd0, count}, 32'd8);
    model_en = 1'b1;
    run = 1'b1;
    push(24'hC00001, 1'b1);
    chk("push_pop_full_count", {28'd0, count}, 32'd8);
    chk("push_pop_no_overflow", {31'd0, overflow}, 32'd0);
    chk("push_pop_issue", {31'd0, new_func}, 32'd1);
    wait_idle(300, "full_drain");
    chk("full_issue_count", n_issue, 14);

    // ---------------- early-done filter ----------------
    model_en = 1'b0;
    run = 1'b0;
    push(24'h300001, 1'b1);
    push(24'h300002, 1'b1);
    push(24'h300003, 1'b1);
    man_done = 1'b1;
    rec_cyc  = 1'b1;
    run = 1'b1;
    wait_idle(100, "early_done_drain");
    man_done = 1'b0;
    rec_cyc  = 1'b0;
    chk("early_issue_count", issue_cyc.size(), 3);
    if (issue_cyc.size() == 3) begin
      chk("early_spacing_1", issue_cyc[1] - issue_cyc[0], 3);
      chk("early_spacing_2", issue_cyc[2] - issue_cyc[1], 3);
    end

    // ---------------- timeout / indefinite wait ----------------
    push(24'h400001, 1'b1);
    push(24'h400002, 1'b1);
    n = 0;
    while (!new_func && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_first_issue", {31'd0, new_func}, 32'd1);
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    @(negedge clk);
    chk("issue_after_timeout", {31'd0, new_func}, 32'd1);
    repeat (TIMEOUT + 4) @(negedge clk);
    chk("second_timeout_idle", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("timeout_err_cleared", {31'd0, timeout_err}, 32'd0);
`else
    repeat (40) @(negedge clk);
    chk("wait_indefinite_busy", {31'd0, busy}, 32'd1);
    chk("wait_indefinite_count", {28'd0, count}, 32'd1);
    chk("timeout_err_tied", {31'd0, timeout_err}, 32'd0);
`endif
    man_done = 1'b1;
    wait_idle(50, "final_drain");
    man_done = 1'b0;
    chk("final_issue_count", n_issue, 19);

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
